fft_frame_sequencer: RTL and testbench

- Sequences the 16-point in-place radix-2 FFT datapath: input mux selects, twiddle selects, register-file write addresses and the result-capture strobe.
- Runs one load stage and three feedback stages per frame on a start/done handshake, then pulses RD_en so the top level captures Y_0..Y_15.
- Sits beside the FFT top level and drives its S / W_sel / Add_sel / RD_en nets.

---
 rtl/fft_ctrl_pkg.sv | 21 ++
 rtl/fft_sel_rom.sv | 18 +
 rtl/fft_frame_sequencer.sv | 89 ++++++++
 tb/tb_fft_frame_sequencer.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/fft_ctrl_pkg.sv
// fft_ctrl_pkg: shared state encoding, select-bus layout and lookup helpers for the FFT frame sequencer.
package fft_ctrl_pkg;
  typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_e;
  localparam int N_POINTS = 16;
  localparam int S_W = 28;
  localparam int W_W = 24;
  localparam int A_W = 64;
  // Highest feedback code per input mux: 4:1 muxes use 3, 3:1 use 2, 2:1 use 1
  localparam int MAXCODE [N_POINTS] = '{3, 3, 3, 3, 2, 2, 2, 2, 1, 1, 1, 1, 3, 3, 3, 3};
  localparam int S_WID [N_POINTS] = '{2, 2, 2, 2, 2, 2, 2, 2, 1, 1, 1, 1, 2, 2, 2, 2};
  localparam int S_OFF [N_POINTS] = '{0, 2, 4, 6, 8, 10, 12, 14, 16, 17, 18, 19, 20, 22, 24, 26};
  localparam logic [A_W-1:0] ADD_ID = 64'hFEDC_BA98_7654_3210;
  function automatic logic [2:0] tw_idx(input int k, input logic [1:0] s);
    int sh;
    sh = int'(s);
    return 3'((k % (1 << sh)) << (3 - sh));
  endfunction
  function automatic logic [1:0] s_code(input int m, input logic [1:0] s);
    return (int'(s) > MAXCODE[m]) ? 2'(MAXCODE[m]) : s;
  endfunction
endpackage

// File: rtl/fft_sel_rom.sv
// fft_sel_rom: combinational stage -> {S, W_sel, Add_sel} lookup.
module fft_sel_rom
  import fft_ctrl_pkg::*;
(
  input  logic [1:0]     stage_i,
  output logic [S_W-1:0] s_o,
  output logic [W_W-1:0] w_o,
  output logic [A_W-1:0] add_o
);
  // Fields never overlap and 1-bit fields only ever carry 0/1, so OR-packing is exact
  always_comb begin
    s_o = '0;
    w_o = '0;
    for (int m = 0; m < N_POINTS; m++) s_o = s_o | (S_W'(s_code(m, stage_i)) << S_OFF[m]);
    for (int k = 0; k < N_POINTS / 2; k++) w_o[3*k +: 3] = tw_idx(k, stage_i);
  end
  assign add_o = ADD_ID;
endmodule

// File: rtl/fft_frame_sequencer.sv
// fft_frame_sequencer: per-frame load/run/done sequencing of the 16-point radix-2 FFT datapath selects.
module fft_frame_sequencer
  import fft_ctrl_pkg::*;
#(
  parameter int N_STAGES     = 4,
  parameter int STAGE_CYCLES = 1,
  parameter int CNT_W        = 4
) (
  input  logic           CLK,
  input  logic           RST,
  input  logic           start,
  input  logic           abort,
  output logic           busy,
  output logic [1:0]     stage,
  output logic [S_W-1:0] S,
  output logic [W_W-1:0] W_sel,
  output logic [A_W-1:0] Add_sel,
  output logic           wr_en,
  output logic           RD_en,
  output logic           done
);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STAGE_CYCLES - 1);
  state_e           state_q, state_d;
  logic [1:0]       stage_q, stage_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [S_W-1:0]   s_q, s_d;
  logic [W_W-1:0]   w_q, w_d;
  logic [A_W-1:0]   add_q, add_d;
  logic             busy_q, busy_d, wr_q, wr_d, rd_q, rd_d;
  always_comb begin
    state_d = state_q;
    stage_d = stage_q;
    cnt_d   = '0;
    if (state_q == IDLE) state_d = (start && !abort) ? LOAD : IDLE;
    else if (state_q == DONE) state_d = IDLE;
    else if (abort) begin
      state_d = IDLE;
      stage_d = '0;
    end else if (cnt_q != CNT_LAST) cnt_d = cnt_q + 1'b1;
    else if (stage_q == 2'(N_STAGES - 1)) begin
      state_d = DONE;
      stage_d = '0;
    end else begin
      state_d = RUN;
      stage_d = stage_q + 1'b1;
    end
    busy_d = (state_d == LOAD) || (state_d == RUN);
    wr_d   = busy_d && (cnt_d == CNT_LAST);
    rd_d   = state_d == DONE;
  end
  // Selects are looked up from the next stage so they register alongside it
  fft_sel_rom u_rom (
    .stage_i(stage_d),
    .s_o    (s_d),
    .w_o    (w_d),
    .add_o  (add_d)
  );
  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_q <= IDLE;
      stage_q <= '0;
      cnt_q   <= '0;
      s_q     <= '0;
      w_q     <= '0;
      add_q   <= ADD_ID;
      busy_q  <= 1'b0;
      wr_q    <= 1'b0;
      rd_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      stage_q <= stage_d;
      cnt_q   <= cnt_d;
      s_q     <= s_d;
      w_q     <= w_d;
      add_q   <= add_d;
      busy_q  <= busy_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
    end
  end
  assign busy    = busy_q;
  assign stage   = stage_q;
  assign S       = s_q;
  assign W_sel   = w_q;
  assign Add_sel = add_q;
  assign wr_en   = wr_q;
  assign RD_en   = rd_q;
  assign done    = rd_q;
endmodule

// File: tb/tb_fft_frame_sequencer.sv
// tb_fft_frame_sequencer: frame-position model plus directed checks for 1- and 3-cycle stage variants.
module tb_fft_frame_sequencer;
  logic CLK = 0, RST = 0, start = 0, abort = 0;
  logic        b1, b3, wr1, wr3, rd1, rd3, dn1, dn3;
  logic [1:0]  st1, st3;
  logic [27:0] s1, s3;
  logic [23:0] w1, w3;
  logic [63:0] a1, a3;
  int n_cmp = 0, n_bad = 0;
  int p1 = -1, p3 = -1, cyc = 0, c0, wc1, wc3;
  bit armed = 0;
  int q1[$], q3[$];

  fft_frame_sequencer #(.STAGE_CYCLES(1)) dut1 (
    .CLK(CLK), .RST(RST), .start(start), .abort(abort), .busy(b1), .stage(st1), .S(s1),
    .W_sel(w1), .Add_sel(a1), .wr_en(wr1), .RD_en(rd1), .done(dn1));
  fft_frame_sequencer #(.STAGE_CYCLES(3)) dut3 (
    .CLK(CLK), .RST(RST), .start(start), .abort(abort), .busy(b3), .stage(st3), .S(s3),
    .W_sel(w3), .Add_sel(a3), .wr_en(wr3), .RD_en(rd3), .done(dn3));

  always #5 CLK = ~CLK;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Frame position: -1 idle, 0..4*sc-1 inside the frame, 4*sc the done cycle
  function automatic int nxt(input int p, input int sc);
    if (!RST) return -1;
    if (p < 0) return (start && !abort) ? 0 : -1;
    if (p == 4 * sc || abort) return -1;
    return p + 1;
  endfunction

  function automatic logic [27:0] exp_s(input int st);
    logic [27:0] r;
    int off, mc, c;
    r = '0;
    off = 0;
    for (int m = 0; m < 16; m++) begin
      mc = m < 4 ? 3 : m < 8 ? 2 : m < 12 ? 1 : 3;
      c = st < mc ? st : mc;
      r = r | (28'(c) << off);
      off += (mc == 1) ? 1 : 2;
    end
    return r;
  endfunction

  function automatic logic [23:0] exp_w(input int st);
    logic [23:0] r;
    r = '0;
    for (int k = 0; k < 8; k++) r[3*k +: 3] = 3'((k % (1 << st)) << (3 - st));
    return r;
  endfunction

  task automatic cmp(input string t, input int p, input int sc, input logic [1:0] stg,
                     input logic [27:0] s, input logic [23:0] w, input logic [63:0] a,
                     input logic bz, input logic wr, input logic rd, input logic dn);
    bit act;
    int es;
    act = p >= 0 && p < 4 * sc;
    es = act ? p / sc : 0;
    chk({t, "_stage"}, stg, es);
    chk({t, "_S"}, s, exp_s(es));
    chk({t, "_W"}, w, exp_w(es));
    chk({t, "_add"}, a, 64'hFEDC_BA98_7654_3210);
    chk({t, "_busy"}, bz, act);
    chk({t, "_wr"}, wr, act && (p % sc == sc - 1));
    chk({t, "_rd"}, rd, p == 4 * sc);
    chk({t, "_done"}, dn, p == 4 * sc);
  endtask

  always @(posedge CLK) begin
    if (!RST) armed <= 1;
    p1 <= nxt(p1, 1);
    p3 <= nxt(p3, 3);
    cyc <= cyc + 1;
  end

  always @(negedge CLK) begin
    if (armed) begin
      cmp("m1", p1, 1, st1, s1, w1, a1, b1, wr1, rd1, dn1);
      cmp("m3", p3, 3, st3, s3, w3, a3, b3, wr3, rd3, dn3);
      if (rd1) q1.push_back(cyc);
      if (rd3) q3.push_back(cyc);
      if (wr1) wc1++;
      if (wr3) wc3++;
    end
  end

  task automatic step();
    @(posedge CLK);
    #2;
  endtask

  task automatic clr();
    q1.delete();
    q3.delete();
    wc1 = 0;
    wc3 = 0;
  endtask

  task automatic chk_idle(input string t);
    chk({t, "_busy"}, b1, 0);
    chk({t, "_stage"}, st1, 0);
    chk({t, "_S"}, s1, 0);
    chk({t, "_W"}, w1, 0);
    chk({t, "_wr"}, wr1, 0);
    chk({t, "_rd"}, rd1, 0);
    chk({t, "_add"}, a1, 64'hFEDC_BA98_7654_3210);
    chk({t, "_busy3"}, b3, 0);
  endtask

  initial begin
    repeat (2) step();
    RST = 1;
    repeat (4) step();
    chk_idle("reset");
    // nominal frame
    clr();
    start = 1;
    step();
    start = 0;
    c0 = cyc;
    @(negedge CLK);
    chk("nom_c1_stage", st1, 0); chk("nom_c1_wr", wr1, 1); chk("nom_c1_busy", b1, 1); chk("nom_c1_S", s1, 0);
    @(negedge CLK);
    chk("nom_c2_stage", st1, 1); chk("nom_c2_S", s1, 28'h55F5555); chk("nom_c2_W", w1, 24'o40404040);
    @(negedge CLK);
    chk("nom_c3_stage", st1, 2); chk("nom_c3_S", s1, 28'hAAFAAAA); chk("nom_c3_W", w1, 24'o64206420);
    @(negedge CLK);
    chk("nom_c4_stage", st1, 3); chk("nom_c4_S", s1, 28'hFFFAAFF); chk("nom_c4_W", w1, 24'o76543210);
    chk("nom_c4_rd", rd1, 0);
    @(negedge CLK);
    chk("nom_c5_rd", rd1, 1); chk("nom_c5_done", dn1, 1); chk("nom_c5_busy", b1, 0); chk("nom_c5_W", w1, 0);
    @(negedge CLK);
    chk("nom_c6_rd", rd1, 0);
    repeat (12) step();
    chk("nom_rd1_count", q1.size(), 1);
    if (q1.size() == 1) chk("nom_rd1_latency", q1[0] - c0, 4);
    chk("nom_rd3_count", q3.size(), 1);
    if (q3.size() == 1) chk("nom_rd3_latency", q3[0] - c0, 12);
    chk("nom_wr1_pulses", wc1, 4);
    chk("nom_wr3_pulses", wc3, 4);
    // start while busy is ignored
    clr();
    start = 1;
    step();
    start = 0;
    step();
    start = 1;
    step();
    start = 0;
    repeat (20) step();
    chk("busy_start_rd1", q1.size(), 1);
    chk("busy_start_rd3", q3.size(), 1);
    // continuous start
    clr();
    start = 1;
    repeat (40) step();
    start = 0;
    repeat (20) step();
    chk("b2b_rd1_enough", q1.size() >= 5, 1);
    chk("b2b_rd3_enough", q3.size() >= 2, 1);
    for (int i = 1; i < q1.size(); i++) chk("b2b_gap1", q1[i] - q1[i-1], 6);
    for (int i = 1; i < q3.size(); i++) chk("b2b_gap3", q3[i] - q3[i-1], 14);
    // abort in stage 2
    clr();
    start = 1;
    step();
    start = 0;
    repeat (2) step();
    chk("abort_pre_stage", st1, 2);
    abort = 1;
    step();
    abort = 0;
    chk_idle("abort");
    repeat (20) step();
    chk("abort_no_rd1", q1.size(), 0);
    chk("abort_no_rd3", q3.size(), 0);
    start = 1;
    step();
    start = 0;
    repeat (20) step();
    chk("post_abort_rd1", q1.size(), 1);
    chk("post_abort_rd3", q3.size(), 1);
    // reset mid-frame
    clr();
    start = 1;
    step();
    start = 0;
    step();
    RST = 0;
    step();
    RST = 1;
    chk_idle("midrst");
    repeat (20) step();
    chk("midrst_no_rd1", q1.size(), 0);
    chk("midrst_no_rd3", q3.size(), 0);
    // abort wins over start in idle
    abort = 1;
    start = 1;
    step();
    abort = 0;
    start = 0;
    chk_idle("abort_start");
    repeat (10) step();
    chk("abort_start_no_rd", q1.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
